// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control path: opcodes, FSM states,
// instruction classes and datapath mux selects.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_ALUR   = 7'b0110011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECR    = 4'd6,
        ST_EXECI    = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_TRAP     = 4'd10
    } state_e;

    typedef enum logic [2:0] {
        IC_LOAD,
        IC_STORE,
        IC_BRANCH,
        IC_ALUI,
        IC_ALUR,
        IC_ILLEGAL
    } iclass_e;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'd0,
        SRCA_OLDPC = 2'd1,
        SRCA_RS1   = 2'd2
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'd0,
        SRCB_IMM  = 2'd1,
        SRCB_FOUR = 2'd2
    } alu_src_b_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2
    } alu_op_e;

    typedef enum logic [1:0] {
        IMM_I    = 2'd0,
        IMM_S    = 2'd1,
        IMM_B    = 2'd2,
        IMM_NONE = 2'd3
    } imm_sel_e;

endpackage

// File: rtl/riscv_opcode_class.sv
// Combinational instruction classifier: maps opcode/funct3 onto the classes the
// control FSM distinguishes; anything unsupported is reported as illegal.
module riscv_opcode_class
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    output iclass_e    iclass_o
);

    always_comb begin
        iclass_o = IC_ILLEGAL;
        case (opcode_i)
            OP_LOAD:   iclass_o = IC_LOAD;
            OP_STORE:  iclass_o = IC_STORE;
            OP_ALUI:   iclass_o = IC_ALUI;
            OP_ALUR:   iclass_o = IC_ALUR;
            OP_BRANCH: begin
                if (funct3_i == F3_BEQ || funct3_i == F3_BNE) begin
                    iclass_o = IC_BRANCH;
                end
            end
            default: iclass_o = IC_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/riscv_mc_control.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback over a
// shared ALU and unified memory port, and counts retired instructions.
module riscv_mc_control
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 adr_src,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 result_src,
    output logic [1:0]           imm_sel,
    output logic                 illegal,
    output logic [3:0]           state,
    output logic [INSTRET_W-1:0] instret
);

    state_e                 state_q, state_d;
    logic                   run_q;
    logic [INSTRET_W-1:0]   instret_q, instret_d;
    logic                   retire;
    iclass_e                iclass;

    riscv_opcode_class u_class (
        .opcode_i (opcode),
        .funct3_i (funct3),
        .iclass_o (iclass)
    );

    // run_q holds every output low until the first clock edge after reset release,
    // so the first memory request appears only after that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            run_q     <= 1'b0;
            instret_q <= '0;
        end else begin
            run_q     <= 1'b1;
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        if (run_q) begin
            case (state_q)
                ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
                ST_DECODE: begin
                    case (iclass)
                        IC_LOAD, IC_STORE: state_d = ST_MEMADR;
                        IC_ALUI:           state_d = ST_EXECI;
                        IC_ALUR:           state_d = ST_EXECR;
                        IC_BRANCH:         state_d = ST_BRANCH;
                        default:           state_d = ST_TRAP;
                    endcase
                end
                ST_MEMADR:   state_d = (iclass == IC_LOAD) ? ST_MEMREAD : ST_MEMWRITE;
                ST_MEMREAD:  if (mem_ready) state_d = ST_MEMWB;
                ST_MEMWB: begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end
                ST_MEMWRITE: begin
                    if (mem_ready) begin
                        state_d = ST_FETCH;
                        retire  = 1'b1;
                    end
                end
                ST_EXECR, ST_EXECI: state_d = ST_ALUWB;
                ST_ALUWB, ST_BRANCH: begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end
                ST_TRAP:     state_d = ST_TRAP;
                default:     state_d = ST_TRAP;
            endcase
        end
    end

    assign instret_d = retire ? instret_q + INSTRET_W'(1) : instret_q;

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_ADD;
        result_src = 1'b0;
        imm_sel    = IMM_I;
        illegal    = 1'b0;
        if (run_q) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_a = SRCA_PC;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                ST_DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    imm_sel   = IMM_B;
                end
                ST_MEMADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    imm_sel   = (iclass == IC_STORE) ? IMM_S : IMM_I;
                end
                ST_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                ST_MEMWB: begin
                    reg_write  = 1'b1;
                    result_src = 1'b1;
                end
                ST_MEMWRITE: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    adr_src = 1'b1;
                end
                ST_EXECR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_RS2;
                    alu_op    = ALU_FUNCT;
                end
                ST_EXECI: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    imm_sel   = IMM_I;
                    alu_op    = ALU_FUNCT;
                end
                ST_ALUWB:  reg_write = 1'b1;
                ST_BRANCH: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_RS2;
                    alu_op    = ALU_SUB;
                    pc_write  = (funct3 == F3_BNE) ? !zero : zero;
                end
                ST_TRAP:   illegal = 1'b1;
                default:   illegal = 1'b1;
            endcase
        end
    end

    assign state   = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_riscv_mc_control.sv
// Scoreboarded bench for riscv_mc_control: instruction-level reference model feeds
// per-cycle expectations to a queue that a negedge monitor drains and compares.
module tb_riscv_mc_control;
    import riscv_ctrl_pkg::*;

    localparam int unsigned IW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    opcode = '0;
    logic [2:0]    funct3 = '0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]    alu_src_a, alu_src_b, alu_op, imm_sel;
    logic          result_src, illegal;
    logic [3:0]    state;
    logic [IW-1:0] instret;

    riscv_mc_control #(.INSTRET_W(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct3     (funct3),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .result_src (result_src),
        .imm_sel    (imm_sel),
        .illegal    (illegal),
        .state      (state),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]    st;
        logic          mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
        logic [1:0]    a, b, op;
        logic          result_src;
        logic [1:0]    imm;
        logic          illegal;
        logic [IW-1:0] instret;
    } obs_t;

    obs_t        expq[$];
    string       nameq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned m_instret = 0;

    function automatic obs_t get_obs();
        obs_t o;
        o.st = state; o.mem_req = mem_req; o.mem_we = mem_we; o.adr_src = adr_src;
        o.ir_write = ir_write; o.pc_write = pc_write; o.reg_write = reg_write;
        o.a = alu_src_a; o.b = alu_src_b; o.op = alu_op; o.result_src = result_src;
        o.imm = imm_sel; o.illegal = illegal; o.instret = instret;
        return o;
    endfunction

    // 0 load, 1 store, 2 branch, 3 alu-imm, 4 alu-reg, 5 illegal
    function automatic int classify(input logic [6:0] opc, input logic [2:0] f3);
        if (opc == 7'b0000011) return 0;
        if (opc == 7'b0100011) return 1;
        if (opc == 7'b1100011) return (f3 == 3'd0 || f3 == 3'd1) ? 2 : 5;
        if (opc == 7'b0010011) return 3;
        if (opc == 7'b0110011) return 4;
        return 5;
    endfunction

    // Output table per state, using the numeric select encodings of the interface.
    function automatic obs_t exp_out(input state_e st);
        obs_t e = '0;
        e.st = st;
        e.instret = IW'(m_instret);
        case (st)
            ST_FETCH:    begin e.mem_req = 1; e.b = 2; e.ir_write = mem_ready; e.pc_write = mem_ready; end
            ST_DECODE:   begin e.a = 1; e.b = 1; e.imm = 2; end
            ST_MEMADR:   begin e.a = 2; e.b = 1; e.imm = (opcode == 7'b0100011) ? 2'd1 : 2'd0; end
            ST_MEMREAD:  begin e.mem_req = 1; e.adr_src = 1; end
            ST_MEMWB:    begin e.reg_write = 1; e.result_src = 1; end
            ST_MEMWRITE: begin e.mem_req = 1; e.mem_we = 1; e.adr_src = 1; end
            ST_EXECR:    begin e.a = 2; e.b = 0; e.op = 2; end
            ST_EXECI:    begin e.a = 2; e.b = 1; e.op = 2; e.imm = 0; end
            ST_ALUWB:    e.reg_write = 1;
            ST_BRANCH:   begin e.a = 2; e.op = 1; e.pc_write = (funct3 == 3'd1) ? !zero : zero; end
            default:     e.illegal = 1;
        endcase
        return e;
    endfunction

    task automatic push_step(input obs_t e, input string nm);
        expq.push_back(e);
        nameq.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input state_e st, input string nm);
        push_step(exp_out(st), nm);
    endtask

    task automatic rnd_in();
        mem_ready = 1'($urandom_range(0, 1));
        zero      = 1'($urandom_range(0, 1));
    endtask

    task automatic retire();
        m_instret = (m_instret + 1) % (1 << IW);
    endtask

    // Reset taken between edges must blank outputs before any clock edge; the
    // first edge after release is still a silent cycle.
    task automatic do_reset();
        rst_n = 1'b0;
        m_instret = 0;
        rnd_in();
        push_step('0, "reset_async");
        rnd_in();
        push_step('0, "reset_hold");
        rst_n = 1'b1;
        rnd_in();
        push_step('0, "post_reset_idle");
    endtask

    task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3,
                             input int wf, input int wm, input int zf);
        int cls;
        opcode = opc;
        funct3 = f3;
        cls = classify(opc, f3);
        for (int i = 0; i < wf; i++) begin
            mem_ready = 1'b0; zero = 1'($urandom_range(0, 1));
            step(ST_FETCH, "fetch_wait");
        end
        mem_ready = 1'b1;
        step(ST_FETCH, "fetch");
        rnd_in();
        step(ST_DECODE, "decode");
        case (cls)
            0, 1: begin
                rnd_in();
                step(ST_MEMADR, "memadr");
                for (int i = 0; i < wm; i++) begin
                    mem_ready = 1'b0; zero = 1'($urandom_range(0, 1));
                    step(cls == 0 ? ST_MEMREAD : ST_MEMWRITE, "mem_wait");
                end
                mem_ready = 1'b1;
                if (cls == 0) begin
                    step(ST_MEMREAD, "memread");
                    rnd_in();
                    step(ST_MEMWB, "memwb");
                end else begin
                    step(ST_MEMWRITE, "memwrite");
                end
                retire();
            end
            2: begin
                rnd_in();
                if (zf >= 0) zero = 1'(zf);
                step(ST_BRANCH, "branch");
                retire();
            end
            3, 4: begin
                rnd_in();
                step(cls == 3 ? ST_EXECI : ST_EXECR, "exec");
                rnd_in();
                step(ST_ALUWB, "aluwb");
                retire();
            end
            default: begin
                for (int i = 0; i < 3; i++) begin
                    rnd_in();
                    step(ST_TRAP, "trap");
                end
                do_reset();
            end
        endcase
    endtask

    task automatic lw_reset_in_memread();
        opcode = 7'b0000011; funct3 = 3'd2;
        mem_ready = 1'b1;
        step(ST_FETCH, "rst_fetch");
        rnd_in();
        step(ST_DECODE, "rst_decode");
        rnd_in();
        step(ST_MEMADR, "rst_memadr");
        mem_ready = 1'b0;
        step(ST_MEMREAD, "rst_memread");
        do_reset();
    endtask

    always @(negedge clk) begin
        if (expq.size() != 0) begin
            obs_t e, a;
            string nm;
            e = expq.pop_front();
            nm = nameq.pop_front();
            a = get_obs();
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s @%0t: got %h expected %h", nm, $time, a, e);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] opc;
        int kind;
        @(posedge clk);
        #1;
        do_reset();
        run_instr(7'b0010011, 3'd0, 0, 0, -1);
        run_instr(7'b0000011, 3'd2, 2, 2, -1);
        run_instr(7'b0100011, 3'd2, 0, 0, -1);
        run_instr(7'b1100011, 3'd0, 0, 0, 1);
        run_instr(7'b1100011, 3'd1, 0, 0, 1);
        run_instr(7'b0110011, 3'd7, 1, 0, -1);
        run_instr(7'h7F, 3'd0, 0, 0, -1);
        run_instr(7'b1100011, 3'd4, 0, 0, -1);
        run_instr(7'b0010011, 3'd3, 0, 0, -1);
        lw_reset_in_memread();
        for (int n = 0; n < 300; n++) begin
            kind = int'($urandom_range(0, 19));
            case (kind)
                0, 1, 2:    opc = 7'b0000011;
                3, 4, 5:    opc = 7'b0100011;
                6, 7, 8, 9: opc = 7'b1100011;
                10, 11, 12: opc = 7'b0010011;
                13, 14, 15: opc = 7'b0110011;
                16:         opc = 7'($urandom);
                default:    opc = 7'b0010011;
            endcase
            if (kind == 18) begin
                lw_reset_in_memread();
            end else begin
                run_instr(opc,
                          (kind >= 6 && kind <= 9 && kind != 9) ? 3'($urandom_range(0, 1))
                                                                  : 3'($urandom),
                          ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
                          ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
                          -1);
            end
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (expq.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
